// File: rtl/rc4_pkg.sv
// Shared definitions for the rc4 key path.
//   RC4_KEY_SIZE   : default key length in bytes, shared with the rc4 core
//   loader_state_e : rc4_key_loader FSM state encodings
package rc4_pkg;

  localparam int unsigned RC4_KEY_SIZE = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_CORE_RST = 3'd2,
    ST_FEED     = 3'd3,
    ST_WAIT     = 3'd4,
    ST_RUN      = 3'd5
  } loader_state_e;

endpackage

// File: rtl/rc4_key_buf.sv
// KEY_SIZE x 8 key register file for rc4_key_loader.
//   clk, rst : clock; async active-high reset (clears contents only when
//              RC4_KEY_ZEROIZE_EN is defined)
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : combinational read port
//   clear            : synchronous clear of all entries (RC4_KEY_ZEROIZE_EN
//                      only; ignored otherwise)
module rc4_key_buf #(
  parameter int unsigned KEY_SIZE = 16,
  parameter int unsigned AW       = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata,
  input  logic          clear
);

  logic [7:0] mem [KEY_SIZE];

`ifdef RC4_KEY_ZEROIZE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (clear) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
`else
  // Key persists until overwritten; reset and clear have no effect here.
  logic unused_ctl;
  assign unused_ctl = rst | clear;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end
`endif

  assign rdata = mem[raddr];

endmodule

// File: rtl/rc4_key_loader.sv
// Key loader in front of the rc4 PRGA core. Buffers a host key received over
// a valid/ready byte interface, holds the core in reset, then streams the key
// on core_key so the core samples buf[n] on the (n+1)th edge after core_rst
// falls. Re-keying is accepted while the core runs.
//   clk, rst   : clock; async active-high reset
//   key_byte, key_valid, key_ready : host byte stream (transfer = valid & ready)
//   core_rst   : registered reset to the rc4 core
//   core_key   : registered drive of the core's password input
//   core_ready : the core's output_ready
//   keyed      : core runs on the current key and its keystream is valid
//   busy       : loader is in LOAD, CORE_RST, FEED or WAIT
// Optional: define RC4_KEY_ZEROIZE_EN to wipe the buffer once the key has been
// handed to the core (and on rst), and to hold core_key at 0 outside feeding.
module rc4_key_loader #(
  parameter int unsigned KEY_SIZE   = rc4_pkg::RC4_KEY_SIZE,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_byte,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       core_rst,
  output logic [7:0] core_key,
  input  logic       core_ready,
  output logic       keyed,
  output logic       busy
);

  import rc4_pkg::*;

  localparam int unsigned CW = $clog2(KEY_SIZE + 1);
  localparam int unsigned AW = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;
  localparam int unsigned TW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(KEY_SIZE - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [TW-1:0] TMR_LAST = TW'(RST_CYCLES - 1);
  localparam bit            ONE_BYTE = (KEY_SIZE == 1);

  loader_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          key_ready_q, key_ready_d;
  logic          core_rst_q, core_rst_d;
  logic [7:0]    core_key_q, core_key_d;
  logic          keyed_q, keyed_d;
  logic          busy_q, busy_d;

  logic          xfer;
  logic          buf_we;
  logic          buf_clear;
  logic [AW-1:0] buf_waddr;
  logic [AW-1:0] buf_raddr;
  logic [7:0]    buf_rdata;

  assign xfer      = key_valid & key_ready_q;
  assign buf_we    = xfer;
  assign buf_waddr = (state_q == ST_LOAD) ? count_q[AW-1:0] : '0;
  assign buf_raddr = (state_q == ST_FEED) ? idx_q[AW-1:0] : '0;

  rc4_key_buf #(
    .KEY_SIZE (KEY_SIZE),
    .AW       (AW)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (key_byte),
    .raddr (buf_raddr),
    .rdata (buf_rdata),
    .clear (buf_clear)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    core_rst_d = core_rst_q;
    core_key_d = core_key_q;
    keyed_d    = keyed_q;
    buf_clear  = 1'b0;
`ifdef RC4_KEY_ZEROIZE_EN
    core_key_d = '0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          count_d    = CNT_ONE;
          timer_d    = '0;
          core_rst_d = 1'b1;
          state_d    = ONE_BYTE ? ST_CORE_RST : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          if (count_q == CNT_LAST) begin
            timer_d    = '0;
            core_rst_d = 1'b1;
            state_d    = ST_CORE_RST;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
      end
      ST_CORE_RST: begin
        if (timer_q == TMR_LAST) begin
          // buf[0] is presented together with the core_rst fall so that the
          // core's first KEYREAD edge sees it.
          core_rst_d = 1'b0;
          core_key_d = buf_rdata;
          idx_d      = CNT_ONE;
          state_d    = ONE_BYTE ? ST_WAIT : ST_FEED;
`ifdef RC4_KEY_ZEROIZE_EN
          buf_clear  = ONE_BYTE;
`endif
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      ST_FEED: begin
        core_key_d = buf_rdata;
        if (idx_q == CNT_LAST) begin
          state_d = ST_WAIT;
`ifdef RC4_KEY_ZEROIZE_EN
          buf_clear = 1'b1;
`endif
        end else begin
          idx_d = idx_q + CNT_ONE;
        end
      end
      ST_WAIT: begin
        core_key_d = '0;
        if (core_ready) begin
          keyed_d = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        keyed_d = core_ready;
        if (xfer) begin
          // Old key keeps running in the core until CORE_RST is entered.
          count_d = CNT_ONE;
          timer_d = '0;
          keyed_d = 1'b0;
          if (ONE_BYTE) begin
            core_rst_d = 1'b1;
          end
          state_d = ONE_BYTE ? ST_CORE_RST : ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    key_ready_d = state_d inside {ST_IDLE, ST_LOAD, ST_RUN};
    busy_d      = state_d inside {ST_LOAD, ST_CORE_RST, ST_FEED, ST_WAIT};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      key_ready_q <= 1'b1;
      core_rst_q  <= 1'b1;
      core_key_q  <= '0;
      keyed_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      key_ready_q <= key_ready_d;
      core_rst_q  <= core_rst_d;
      core_key_q  <= core_key_d;
      keyed_q     <= keyed_d;
      busy_q      <= busy_d;
    end
  end

  assign key_ready = key_ready_q;
  assign core_rst  = core_rst_q;
  assign core_key  = core_key_q;
  assign keyed     = keyed_q;
  assign busy      = busy_q;

  // The core must never drop output_ready while it is running.
  core_ready_held_in_run: assert property (
    @(posedge clk) disable iff (rst) (state_q == ST_RUN) |-> core_ready
  );

endmodule

// File: doc/rc4_key_loader.md
Name: rc4_key_loader

Overview:
- Upstream stage of the rc4 PRGA core: accepts a key from a host over a valid/ready byte interface and buffers it.
- Holds the core in reset, releases it, and streams the buffered key on the core's password input with exact cycle alignment to its KEYREAD phase.
- Reports when the core's keystream is valid.
- Supports re-keying at any time without a global reset.

Parameters:
- KEY_SIZE, 16: key length in bytes; must equal the core's KEY_SIZE; legal range 1..255.
- RST_CYCLES, 2: number of cycles core_rst is held high before feeding; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- key_byte  in  8  host key byte
- key_valid  in  1  key_byte valid
- key_ready  out  1  loader accepts key_byte this cycle
- core_rst  out  1  reset to rc4 core (registered)
- core_key  out  8  drives the core's password_input (registered)
- core_ready  in  1  the core's output_ready
- keyed  out  1  high when the core is running on the current key and its keystream is valid
- busy  out  1  high in LOAD, CORE_RST, FEED and WAIT

Behaviour:
- Reset values:
  - state IDLE, byte count 0.
  - key_ready=1, core_rst=1 (core held in reset until a key exists), core_key=0, keyed=0, busy=0.
- Transfer rule: a byte transfers on a rising clk edge when key_valid & key_ready.
- States:
  - IDLE: key_ready=1. A transfer writes buf[0], sets count=1 and goes to LOAD, or to CORE_RST if KEY_SIZE==1.
  - LOAD: key_ready=1. Each transfer writes buf[count] and increments count. The transfer with count==KEY_SIZE-1 goes to CORE_RST.
  - CORE_RST: key_ready=0, core_rst=1, timer counts RST_CYCLES edges. On the final edge:
    - core_rst<=0, core_key<=buf[0], idx<=1;
    - go to FEED, or to WAIT if KEY_SIZE==1.
  - FEED: each edge sets core_key<=buf[idx] and idx++. The edge that loads buf[KEY_SIZE-1] goes to WAIT.
    - Net effect: the core samples buf[n] on the (n+1)th edge after core_rst falls, for n=0..KEY_SIZE-1.
  - WAIT: core_key<=0. core_ready==1 sampled goes to RUN, with keyed<=1 on the same edge.
  - RUN: key_ready=1. keyed = registered (core_ready in RUN).
    - A transfer writes buf[0], sets count=1, keyed<=0, and goes to LOAD (or to CORE_RST if KEY_SIZE==1).
    - The core keeps running on the old key until CORE_RST.
- Latency, from the last key byte accepted to core_rst low: RST_CYCLES edges.
- Latency to keyed: that, plus KEY_SIZE, plus the core's schedule and discard time.
- Transfers while key_ready=0 are ignored (no write); the host must hold key_valid.
- Counters are $clog2(KEY_SIZE+1) bits and never wrap: count and idx saturate at their terminal states.
- keyed falls if core_ready drops in RUN, which is illegal for the core; the assertion flags it.
- Async rst mid-operation, any state: the outputs listed under reset values are applied immediately (same cycle) and the partial key is discarded. The buffer contents are don't-care unless zeroize is enabled.

Optional Feature:
- Macro RC4_KEY_ZEROIZE_EN.
- Defined:
  - on the edge leaving FEED, all buf entries are cleared to 0x00;
  - async rst also clears buf;
  - core_key is forced to 0 in every state except FEED and the final CORE_RST edge.
- Undefined: buf retains the key until overwritten; no clearing logic is synthesized.

Decomposition:
- Shared package/include rc4_pkg holds:
  - KEY_SIZE default (the same define the core uses);
  - loader state encodings IDLE=0, LOAD=1, CORE_RST=2, FEED=3, WAIT=4, RUN=5 as 3-bit constants.
- One natural sub-module: rc4_key_buf, a KEY_SIZE x 8 register file with write port (we, waddr, wdata), one read port, and a clear input (tied 0 when zeroize is off).
- The FSM and counters stay in rc4_key_loader.

Test Plan:
- Basic load, KEY_SIZE=4, RST_CYCLES=2. Send bytes 01 02 03 04 back-to-back. Required:
  - key_ready low after the 4th byte;
  - core_rst low exactly 2 edges later;
  - core_key shows 01,02,03,04 on 4 consecutive cycles starting at the core_rst fall;
  - the rc4 model captures key = 01020304.
- Host throttling: key_valid toggles every other cycle. Bytes are accepted only on valid cycles; the same 4-byte key is captured; busy stays high from the first byte to RUN.
- Core handshake: stub core_ready rising 20 cycles after WAIT entry. keyed rises on the following edge, not before.
- Re-key in RUN: send AA BB CC DD. Required:
  - keyed drops on the first accepted byte;
  - core_rst reasserts after the 4th byte;
  - the core receives AA..DD and keyed returns.
- Reset mid-FEED (after 2 bytes fed). Required:
  - core_rst=1, key_ready=1, keyed=0, core_key=0 immediately;
  - a fresh key loads correctly afterwards.
- With RC4_KEY_ZEROIZE_EN: after FEED, peek buf = all 00 and core_key==0 in WAIT/RUN. Without the macro, buf still holds 01 02 03 04.
